// File: rtl/count_generator_pkg.sv
// Shared definitions for the TX count generator: FSM encoding, statistics widths
// and the bit pattern used to corrupt an injected word.
package count_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_BURST = 2'd2,
    ST_GAP   = 2'd3
  } gen_state_e;

  localparam int WORDS_W = 32;
  localparam int ERR_W   = 8;

  // Only bit 0 is flipped so the far-end checker sees a single-bit error
  localparam logic [31:0] INJECT_MASK = 32'h1;

endpackage

// File: rtl/count_generator_if.sv
// Word stream towards the LiteFast TX: data, valid and the IP's ready back-pressure.
interface count_generator_if #(
  parameter int DATA_W = 32
) ();

  logic [DATA_W-1:0] data;
  logic              usr_data_valid;
  logic              tx_ready;

  modport master (output data, output usr_data_valid, input tx_ready);
  modport slave  (input data, input usr_data_valid, output tx_ready);

endinterface

// File: rtl/count_generator_sat_counter.sv
// Statistics counter that sticks at all-ones; clear takes priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + W'(1);
    end
  end

endmodule

// File: rtl/count_generator.sv
// Bursty incrementing-word generator for the LiteFast TX, with link-sync wait,
// idle gaps between bursts and single-word error injection.
module count_generator
  import count_gen_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] SEED        = '0,
  parameter int                BURST_LEN   = 256,
  parameter int                GAP_LEN     = 4,
  parameter int                SYNC_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               inject_err_i,
  input  logic               clear_i,
  count_generator_if.master  tx,
  output logic [WORDS_W-1:0] words_sent_o,
  output logic [ERR_W-1:0]   err_count_o,
  output logic               busy_o
);

  gen_state_e        state_q, state_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              armed_q, armed_d;
  logic              bad_q, bad_d;
  logic              busy_q, busy_d;
  logic [31:0]       sync_q, sync_d;
  logic [31:0]       burst_q, burst_d;
  logic [31:0]       gap_q, gap_d;

  logic              accept;
  logic              load;
  logic              corrupt;
  logic [DATA_W-1:0] load_val;

  assign accept = valid_q & tx.tx_ready;

  // Next-state logic; "load" marks cycles where a fresh word is presented and
  // is the single point where a pending injection gets applied.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = valid_q;
    armed_d  = armed_q;
    bad_d    = bad_q;
    sync_d   = sync_q;
    burst_d  = burst_q;
    gap_d    = gap_q;
    load     = 1'b0;
    load_val = count_q;
    corrupt  = 1'b0;

    if (!armed_q && inject_err_i) armed_d = 1'b1;
    if (accept && bad_q) begin
      armed_d = 1'b0;
      bad_d   = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SYNC;
          sync_d  = '0;
        end
      end
      ST_SYNC: begin
        if (sync_q == SYNC_CYCLES) begin
          state_d  = ST_BURST;
          burst_d  = '0;
          load     = 1'b1;
          load_val = count_q;
        end else if (tx.tx_ready) begin
          sync_d = sync_q + 32'd1;
        end else begin
          sync_d = '0;
        end
      end
      ST_BURST: begin
        if (accept) begin
          count_d = count_q + DATA_W'(1);
          if (burst_q == BURST_LEN - 1) begin
            burst_d = '0;
            if (GAP_LEN == 0) begin
              load     = 1'b1;
              load_val = count_q + DATA_W'(1);
            end else begin
              state_d = ST_GAP;
              gap_d   = '0;
              valid_d = 1'b0;
            end
          end else begin
            burst_d  = burst_q + 32'd1;
            load     = 1'b1;
            load_val = count_q + DATA_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_q + 32'd1 == GAP_LEN) begin
          state_d  = ST_BURST;
          load     = 1'b1;
          load_val = count_q;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      corrupt = armed_d && !bad_d;
      valid_d = 1'b1;
      bad_d   = corrupt;
      data_d  = corrupt ? (load_val ^ DATA_W'(INJECT_MASK)) : load_val;
    end

    // Dropping start abandons everything except the statistics
    if (!start_i) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      data_d  = '0;
      count_d = SEED;
      armed_d = 1'b0;
      bad_d   = 1'b0;
      sync_d  = '0;
      burst_d = '0;
      gap_d   = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      count_q <= SEED;
      data_q  <= '0;
      valid_q <= 1'b0;
      armed_q <= 1'b0;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      sync_q  <= '0;
      burst_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      armed_q <= armed_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
      sync_q  <= sync_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
    end
  end

  assign tx.data           = data_q;
  assign tx.usr_data_valid = valid_q;
  assign busy_o            = busy_q;

  sat_counter #(.W(WORDS_W)) u_words_sent (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .inc_i   (accept),
    .count_o (words_sent_o)
  );

  sat_counter #(.W(ERR_W)) u_err_count (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .inc_i   (accept && bad_q),
    .count_o (err_count_o)
  );

endmodule

// File: tb/tb_count_generator.sv
// Directed plus randomized bench for count_generator against a stream-level model
// (expected word = SEED + number of accepted words, bursts counted arithmetically).
module tb_count_generator;
  import count_gen_pkg::*;

  localparam int          DATA_W      = 32;
  localparam logic [31:0] SEED        = 32'hFFFF_FFFC;
  localparam int          BURST_LEN   = 4;
  localparam int          GAP_LEN     = 2;
  localparam int          SYNC_CYCLES = 16;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        start  = 1'b0;
  logic        inject = 1'b0;
  logic        clear  = 1'b0;
  logic [31:0] words;
  logic [7:0]  errs;
  logic        busy;

  count_generator_if #(.DATA_W(DATA_W)) tx ();

  count_generator #(
    .DATA_W      (DATA_W),
    .SEED        (SEED),
    .BURST_LEN   (BURST_LEN),
    .GAP_LEN     (GAP_LEN),
    .SYNC_CYCLES (SYNC_CYCLES)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .inject_err_i (inject),
    .clear_i      (clear),
    .tx           (tx),
    .words_sent_o (words),
    .err_count_o  (errs),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;

  // Reference model state
  int          mN       = 0;
  int          mGapLeft = 0;
  logic [31:0] mData    = '0;
  logic [31:0] mWords   = '0;
  logic [7:0]  mErrs    = '0;
  bit          mValid   = 1'b0;
  bit          mRunning = 1'b0;
  bit          mPending = 1'b0;
  bit          mBad     = 1'b0;

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("data", tx.data, mData);
    checkOutput("valid", 32'(tx.usr_data_valid), 32'(mValid));
    checkOutput("words_sent", words, mWords);
    checkOutput("err_count", 32'(errs), 32'(mErrs));
    checkOutput("busy", 32'(busy), 32'(mRunning));
  endtask

  // One clock with the given inputs, then advance the model and compare
  task automatic applyStimulus(bit s, bit r, bit inj, bit clr);
    bit acc;
    bit present;
    present     = 1'b0;
    start       = s;
    tx.tx_ready = r;
    inject      = inj;
    clear       = clr;
    @(posedge clk);
    #1;
    acc = mValid && r;
    if (clr) begin
      mWords = '0;
      mErrs  = '0;
    end else if (acc) begin
      if (mWords != 32'hFFFF_FFFF) mWords++;
      if (mBad && mErrs != 8'hFF) mErrs++;
    end
    if (!s) begin
      mRunning = 1'b0;
      mValid   = 1'b0;
      mData    = '0;
      mN       = 0;
      mPending = 1'b0;
      mBad     = 1'b0;
    end else begin
      if (inj && !mPending && !mBad) mPending = 1'b1;
      if (acc && mBad) mBad = 1'b0;
      if (mValid) begin
        if (acc) begin
          mN++;
          if ((mN % BURST_LEN) == 0 && GAP_LEN > 0) begin
            mValid   = 1'b0;
            mGapLeft = GAP_LEN;
          end else begin
            present = 1'b1;
          end
        end
      end else begin
        mGapLeft--;
        if (mGapLeft == 0) present = 1'b1;
      end
      if (present) begin
        mValid   = 1'b1;
        mBad     = mPending;
        mPending = 1'b0;
        mData    = (SEED + 32'(mN)) ^ 32'(mBad);
      end
    end
    checkAll();
  endtask

  // Start from IDLE with the link ready and measure time to first valid word
  task automatic doSync();
    int lat;
    lat         = 0;
    start       = 1'b1;
    tx.tx_ready = 1'b1;
    inject      = 1'b0;
    clear       = 1'b0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!tx.usr_data_valid) checkOutput("sync_busy", 32'(busy), 32'd1);
    end while (!tx.usr_data_valid && lat < 200);
    checkOutput("sync_latency", 32'(lat), 32'(SYNC_CYCLES + 2));
    mRunning = 1'b1;
    mValid   = 1'b1;
    mN       = 0;
    mPending = 1'b0;
    mBad     = 1'b0;
    mData    = SEED;
    checkAll();
  endtask

  initial begin
    int guard;
    tx.tx_ready = 1'b0;

    // Reset state
    reset = 1'b1;
    #12;
    checkAll();
    @(negedge clk);
    reset = 1'b0;

    // Contiguous stream with ready held high, wrapping through zero
    doSync();
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

    // Back-pressure holds the presented word
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

    // Injection, with a second pulse while still armed
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b1, ($urandom % 4) != 0, ($urandom % 12) == 0, ($urandom % 40) == 0);
    end

    // Clear on an accept cycle, then stop
    guard = 0;
    while (!mValid && guard < 10) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("clear_words", words, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stop_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Restart keeps statistics; asynchronous reset mid-burst
    doSync();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    mRunning = 1'b0;
    mValid   = 1'b0;
    mData    = '0;
    mN       = 0;
    mPending = 1'b0;
    mBad     = 1'b0;
    mWords   = '0;
    mErrs    = '0;
    checkAll();
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
